// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
// Build option MEM_ARB_RR_EN selects round-robin tie-break (see mem_arb_pick).
package mem_arb_pkg;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arbState_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } portId_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between port A and port B.
// MEM_ARB_RR_EN defined: round-robin on ties; undefined: A has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    aReq,
    input  logic    bReq,
    input  portId_e lastGrant,
    output logic    grantValid,
    output portId_e grantId
);

`ifdef MEM_ARB_RR_EN
    // On a tie the port that was not served last goes next.
    always_comb begin
        grantValid = aReq | bReq;
        grantId    = PORT_A;
        if (aReq && bReq) begin
            grantId = (lastGrant == PORT_A) ? PORT_B : PORT_A;
        end else if (bReq) begin
            grantId = PORT_B;
        end
    end
`else
    // Fixed priority: lastGrant is kept in the top for the RR build only.
    logic unusedLastGrant;
    assign unusedLastGrant = lastGrant;

    always_comb begin
        grantValid = aReq | bReq;
        grantId    = PORT_A;
        if (!aReq && bReq) begin
            grantId = PORT_B;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared data memory: one access at a time,
// single-cycle enable, fixed MEM_LAT wait, then a one-cycle ack to the winner.
// Tie-break policy chosen by MEM_ARB_RR_EN (round-robin) or fixed A priority.
module mem_arbiter #(
    parameter int unsigned DATA_W  = mem_arb_pkg::DATA_W,
    parameter int unsigned ADDR_W  = mem_arb_pkg::ADDR_W,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              aReq,
    input  logic              aRW,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [DATA_W-1:0] aWData,
    output logic              aAck,
    output logic [DATA_W-1:0] aRData,
    input  logic              bReq,
    input  logic              bRW,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [DATA_W-1:0] bWData,
    output logic              bAck,
    output logic [DATA_W-1:0] bRData,
    output logic              memEN,
    output logic              memRW,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] toMemBus,
    input  logic [DATA_W-1:0] memBus,
    output logic              busy
);

    import mem_arb_pkg::*;

    arbState_e        state;
    arbState_e        stateNext;
    portId_e          winner;
    portId_e          winnerNext;
    portId_e          lastGrant;
    portId_e          lastGrantNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    logic              memENNext;
    logic              memRWNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] toMemBusNext;
    logic [DATA_W-1:0] aRDataNext;
    logic [DATA_W-1:0] bRDataNext;
    logic              aAckNext;
    logic              bAckNext;
    logic              busyNext;

    logic              grantValid;
    portId_e           grantId;

    mem_arb_pick uPick (
        .aReq       (aReq),
        .bReq       (bReq),
        .lastGrant  (lastGrant),
        .grantValid (grantValid),
        .grantId    (grantId)
    );

    // State and every output are registered; next values come from the block below.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            winner    <= PORT_A;
            lastGrant <= PORT_B;
            cnt       <= '0;
            memEN     <= 1'b0;
            memRW     <= 1'b0;
            memAddr   <= '0;
            toMemBus  <= '0;
            aRData    <= '0;
            bRData    <= '0;
            aAck      <= 1'b0;
            bAck      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            winner    <= winnerNext;
            lastGrant <= lastGrantNext;
            cnt       <= cntNext;
            memEN     <= memENNext;
            memRW     <= memRWNext;
            memAddr   <= memAddrNext;
            toMemBus  <= toMemBusNext;
            aRData    <= aRDataNext;
            bRData    <= bRDataNext;
            aAck      <= aAckNext;
            bAck      <= bAckNext;
            busy      <= busyNext;
        end
    end

    // Next-state and next-output decode; pulses default low, data paths hold.
    always_comb begin
        stateNext     = state;
        winnerNext    = winner;
        lastGrantNext = lastGrant;
        cntNext       = cnt;
        memENNext     = 1'b0;
        memRWNext     = memRW;
        memAddrNext   = memAddr;
        toMemBusNext  = toMemBus;
        aRDataNext    = aRData;
        bRDataNext    = bRData;
        aAckNext      = 1'b0;
        bAckNext      = 1'b0;

        case (state)
            IDLE: begin
                if (grantValid) begin
                    winnerNext = grantId;
                    if (grantId == PORT_A) begin
                        memRWNext    = aRW;
                        memAddrNext  = aAddr;
                        toMemBusNext = aWData;
                    end else begin
                        memRWNext    = bRW;
                        memAddrNext  = bAddr;
                        toMemBusNext = bWData;
                    end
                    memENNext = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                cntNext   = CNT_W'(MEM_LAT);
                stateNext = WAIT;
            end
            WAIT: begin
                cntNext = cnt - CNT_W'(1);
                // Last wait cycle: memory data is valid, capture it with the ack.
                if (cnt == CNT_W'(1)) begin
                    if (memRW) begin
                        if (winner == PORT_A) begin
                            aRDataNext = memBus;
                        end else begin
                            bRDataNext = memBus;
                        end
                    end
                    if (winner == PORT_A) begin
                        aAckNext = 1'b1;
                    end else begin
                        bAckNext = 1'b1;
                    end
                    stateNext = RESP;
                end
            end
            RESP: begin
                lastGrantNext = winner;
                stateNext     = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: instance 0 uses MEM_LAT=1,
// instance 1 uses MEM_LAT=4; tie expectations follow MEM_ARB_RR_EN.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rstN;
    logic          aReq [2];
    logic          aRW [2];
    logic [AW-1:0] aAddr [2];
    logic [DW-1:0] aWData [2];
    logic          aAck [2];
    logic [DW-1:0] aRData [2];
    logic          bReq [2];
    logic          bRW [2];
    logic [AW-1:0] bAddr [2];
    logic [DW-1:0] bWData [2];
    logic          bAck [2];
    logic [DW-1:0] bRData [2];
    logic          memEN [2];
    logic          memRW [2];
    logic [AW-1:0] memAddr [2];
    logic [DW-1:0] toMemBus [2];
    logic          busy [2];
    logic          preEn [2];
    logic [AW-1:0] preAddr [2];
    logic [DW-1:0] preData [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gDut
        logic [DW-1:0] mem [256];
        logic [DW-1:0] memBusL;

        mem_arbiter #(
            .DATA_W  (DW),
            .ADDR_W  (AW),
            .MEM_LAT ((g == 0) ? 1 : 4)
        ) uDut (
            .clk      (clk),
            .rstN     (rstN),
            .aReq     (aReq[g]),
            .aRW      (aRW[g]),
            .aAddr    (aAddr[g]),
            .aWData   (aWData[g]),
            .aAck     (aAck[g]),
            .aRData   (aRData[g]),
            .bReq     (bReq[g]),
            .bRW      (bRW[g]),
            .bAddr    (bAddr[g]),
            .bWData   (bWData[g]),
            .bAck     (bAck[g]),
            .bRData   (bRData[g]),
            .memEN    (memEN[g]),
            .memRW    (memRW[g]),
            .memAddr  (memAddr[g]),
            .toMemBus (toMemBus[g]),
            .memBus   (memBusL),
            .busy     (busy[g])
        );

        // Memory model: data for a read is on memBus from the cycle after ISSUE.
        always @(posedge clk) begin
            if (preEn[g]) begin
                mem[preAddr[g]] <= preData[g];
            end else if (memEN[g]) begin
                if (memRW[g]) memBusL <= mem[memAddr[g]];
                else          mem[memAddr[g]] <= toMemBus[g];
            end
        end
    end

    typedef struct {
        int            dut;
        bit            port;
        bit            rw;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any ack against the queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            if (aAck[g] || bAck[g]) begin
                check("ack_exclusive", DW'(aAck[g] & bAck[g]), '0);
                checks++;
                assert (sbq.size() != 0) else begin
                    errors++;
                    $error("FAIL ack_unexpected dut=%0d observed aAck=%0b bAck=%0b expected no ack", g, aAck[g], bAck[g]);
                end
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("ack_dut", DW'(g), DW'(e.dut));
                    check("ack_port", DW'(bAck[g]), DW'(e.port));
                    if (e.rw) check("rdata", bAck[g] ? bRData[g] : aRData[g], e.data);
                end
            end
        end
    endtask

    task automatic checkZero(input int d);
        check("rst_memEN", DW'(memEN[d]), '0);
        check("rst_memRW", DW'(memRW[d]), '0);
        check("rst_memAddr", DW'(memAddr[d]), '0);
        check("rst_toMemBus", toMemBus[d], '0);
        check("rst_aAck", DW'(aAck[d]), '0);
        check("rst_bAck", DW'(bAck[d]), '0);
        check("rst_aRData", aRData[d], '0);
        check("rst_bRData", bRData[d], '0);
        check("rst_busy", DW'(busy[d]), '0);
    endtask

    // One access from one port; checks latency, enable pulse and held address/direction.
    task automatic runAccess(input int d, input bit port, input bit rw, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input int expLat, input logic [DW-1:0] expData);
        exp_t e;
        int   n;
        int   enCount;
        bit   got;
        e.dut = d; e.port = port; e.rw = rw; e.data = expData;
        sbq.push_back(e);
        if (!port) begin
            aReq[d] = 1'b1; aRW[d] = rw; aAddr[d] = addr; aWData[d] = wd;
        end else begin
            bReq[d] = 1'b1; bRW[d] = rw; bAddr[d] = addr; bWData[d] = wd;
        end
        got = 1'b0;
        enCount = 0;
        n = 0;
        while (!got && n < 30) begin
            tick();
            n++;
            if (memEN[d]) enCount++;
            if (n <= expLat - 1) begin
                check("mem_addr", DW'(memAddr[d]), DW'(addr));
                check("mem_rw", DW'(memRW[d]), DW'(rw));
                if (!rw && n == 1) check("to_mem_bus", toMemBus[d], wd);
            end
            if ((port ? bAck[d] : aAck[d]) == 1'b1) begin
                got = 1'b1;
                check("latency", DW'(n), DW'(expLat));
            end
        end
        if (!got) check("ack_timeout", '0, DW'(1));
        check("mem_en_pulses", DW'(enCount), DW'(1));
        aReq[d] = 1'b0;
        bReq[d] = 1'b0;
        tick();
    endtask

    initial begin
        int acks;
        exp_t e;
        rstN = 1'b0;
        for (int g = 0; g < 2; g++) begin
            aReq[g] = 1'b0; aRW[g] = 1'b0; aAddr[g] = '0; aWData[g] = '0;
            bReq[g] = 1'b0; bRW[g] = 1'b0; bAddr[g] = '0; bWData[g] = '0;
            preEn[g] = 1'b0; preAddr[g] = '0; preData[g] = '0;
        end

        @(negedge clk);
        checkZero(0);
        checkZero(1);
        rstN = 1'b1;
        preEn[0] = 1'b1; preAddr[0] = 8'd3; preData[0] = 256'hDEAD;
        preEn[1] = 1'b1; preAddr[1] = 8'd0; preData[1] = 256'hCAFE;
        tick();
        preEn[0] = 1'b0;
        preEn[1] = 1'b0;

        // Single read, then write/read on B; the write must not disturb aRData.
        runAccess(0, 1'b0, 1'b1, 8'd3, '0, 3, 256'hDEAD);
        runAccess(0, 1'b1, 1'b0, 8'd7, 256'h1234, 3, '0);
        check("aRData_after_write", aRData[0], 256'hDEAD);
        runAccess(0, 1'b1, 1'b1, 8'd7, '0, 3, 256'h1234);
        check("aRData_kept", aRData[0], 256'hDEAD);

        // Both ports request continuously for four accesses.
        for (int i = 0; i < 4; i++) begin
            e.dut = 0;
            e.rw = 1'b1;
`ifdef MEM_ARB_RR_EN
            e.port = (i % 2) != 0;
`else
            e.port = 1'b0;
`endif
            e.data = e.port ? 256'h1234 : 256'hDEAD;
            sbq.push_back(e);
        end
        aReq[0] = 1'b1; aRW[0] = 1'b1; aAddr[0] = 8'd3;
        bReq[0] = 1'b1; bRW[0] = 1'b1; bAddr[0] = 8'd7;
        acks = 0;
        for (int c = 0; c < 40 && acks < 4; c++) begin
            tick();
            if (aAck[0] || bAck[0]) acks++;
        end
        aReq[0] = 1'b0;
        bReq[0] = 1'b0;
        check("tie_ack_count", DW'(acks), DW'(4));
        tick();
        tick();
        check("tie_sb_empty", DW'(sbq.size()), '0);

        // Reset in the middle of WAIT aborts the access with no ack.
        aReq[0] = 1'b1; aRW[0] = 1'b1; aAddr[0] = 8'd3;
        tick();
        tick();
        check("mid_busy", DW'(busy[0]), DW'(1));
        rstN = 1'b0;
        aReq[0] = 1'b0;
        #1;
        checkZero(0);
        @(negedge clk);
        rstN = 1'b1;
        tick();
        tick();
        check("post_rst_idle", DW'(busy[0]), '0);
        runAccess(0, 1'b0, 1'b1, 8'd3, '0, 3, 256'hDEAD);

        // MEM_LAT=4 instance.
        runAccess(1, 1'b0, 1'b1, 8'd0, '0, 6, 256'hCAFE);
        check("lat4_bAck_quiet", DW'(bRData[1]), '0);

        check("sb_empty", DW'(sbq.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
